divider_iter: RTL and testbench
===============================

Name: divider_iter

Overview:
- Parameterised multi-cycle radix-2 restoring divider; the next generation of the team's divider cells.
- Replaces the fully unrolled pipeline with a single reused stage that produces one quotient bit per cycle.
- Adds per-transaction signed/unsigned mode, a divide-by-zero flag, a request tag, and valid/ready handshakes on both sides.
- Sits between the datapath issue logic and the result writeback stage.

Parameters:
- N, 16: dividend and quotient width (N >= 2).
- M, 8: divisor and remainder width (2 <= M <= N).
- TW, 4: tag width, passed through unchanged.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- signed_op  in  1  1 = two's-complement operands, 0 = unsigned.
- dividend  in  N  dividend.
- divisor  in  M  divisor.
- tag_in  in  TW  request tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- quotient  out  N  quotient.
- remainder  out  M  remainder.
- div_zero  out  1  divisor was zero.
- tag_out  out  TW  tag of the result.

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - Outputs: in_ready=1, out_valid=0; quotient, remainder, div_zero and tag_out = 0.
  - The iteration counter and all internal registers are cleared.
  - Any in-flight operation is discarded and produces no output.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, the block latches signed_op, tag_in, the operand magnitudes (absolute values when signed_op=1), the quotient sign and the remainder sign.
  - Quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
  - Divisor == 0 -> DONE. Otherwise -> CALC, with the counter loaded to N-1 and the partial remainder (M+1 bits) cleared.
- CALC, one step per cycle:
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Compare against {1'b0, divisor magnitude}.
  - If greater or equal: subtract and shift a 1 into the quotient. Otherwise shift a 0 in.
  - The counter decrements each step; at count 0 the state moves to FIX.
  - Exactly N iterations are performed.
- FIX:
  - Negate the quotient if the quotient sign is set.
  - Negate the remainder if the remainder sign is set.
  - Register both, then go to DONE.
- DONE:
  - out_valid=1; quotient, remainder, div_zero and tag_out are held stable until out_ready=1.
  - out_valid & out_ready -> IDLE.
- Handshake:
  - in_ready is asserted only in IDLE, so no request is accepted in CALC, FIX or DONE, including the DONE cycle in which out_ready=1.
  - out_valid must never drop without out_ready.
  - Inputs are ignored outside the accept edge.
- Latency:
  - Normal operation: out_valid rises N+1 clock edges after the accepting edge.
  - Divide by zero: out_valid rises 1 edge after the accepting edge.
  - Throughput: at most one result per N+3 cycles with out_ready held at 1.
- Arithmetic rules:
  - Truncation toward zero.
  - dividend = quotient*divisor + remainder, with |remainder| < |divisor|.
  - The remainder takes the sign of the dividend.
  - Results are truncated to N and M bits.
- Signed overflow: most-negative dividend / -1 gives quotient = most-negative value (wraps) and remainder=0, with div_zero=0.
- Most-negative divisor: the magnitude 2^(M-1) must be handled correctly; the M-bit unsigned magnitude plus the M+1-bit compare covers it.
- Divide by zero (both modes):
  - quotient = all ones.
  - remainder = dividend[M-1:0], unmodified.
  - div_zero=1.
- div_zero=0 for every non-zero divisor.

Test Plan:
- Unsigned: N=16, M=8. Accept 1000/7 with signed_op=0 and tag 3 -> exactly 17 edges later out_valid=1, quotient=142 (0x008E), remainder=6, div_zero=0, tag_out=3.
- Signed: -1000/7 (0xFC18 / 0x07) -> quotient=0xFF72 (-142), remainder=0xFA (-6). Also 1000/-7 -> quotient=0xFF72, remainder=0x06.
- Divide by zero: 0x04D2/0x00 -> out_valid 1 edge after accept, quotient=0xFFFF, remainder=0xD2, div_zero=1.
- Signed corner cases:
  - 0x8000 / 0xFF -> quotient=0x8000, remainder=0.
  - 0x8000 / 0x80 -> quotient=0x0100, remainder=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> outputs stay constant and in_ready stays 0.
  - Then out_ready=1 -> in_ready=1 on the next cycle.
  - A back-to-back request is accepted only then.
- Reset mid-operation:
  - Assert rst 5 cycles into CALC -> immediately in_ready=1, out_valid=0 and all outputs 0.
  - Then release rst and run 255/15 unsigned -> quotient=17, remainder=0.

Source files
------------

// File: rtl/divider_iter.sv
// Multi-cycle radix-2 restoring divider: one quotient bit per cycle, signed/unsigned per request,
// divide-by-zero flag, pass-through tag, valid/ready on both sides.
module divider_iter #(
   parameter int unsigned N  = 16,
   parameter int unsigned M  = 8,
   parameter int unsigned TW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          signed_op,
   input  logic [N-1:0]  dividend,
   input  logic [M-1:0]  divisor,
   input  logic [TW-1:0] tag_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  quotient,
   output logic [M-1:0]  remainder,
   output logic          div_zero,
   output logic [TW-1:0] tag_out
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [M:0]      prem_q;
   // Starts as the dividend magnitude; quotient bits shift in from the LSB as dividend bits leave.
   logic [N-1:0]    quo_q;
   logic [M-1:0]    dsr_q;
   logic            q_neg_q;
   logic            r_neg_q;
   logic [TW-1:0]   tag_q;

   logic            dvd_neg;
   logic            dsr_neg;
   logic [N-1:0]    dvd_mag;
   logic [M-1:0]    dsr_mag;
   logic [M:0]      shifted;
   logic [M:0]      diff;
   logic            ge;
   logic            unused_prem_msb;

   assign dvd_neg = signed_op & dividend[N-1];
   assign dsr_neg = signed_op & divisor[M-1];
   // The most-negative values negate to themselves, which read unsigned are the right magnitudes.
   assign dvd_mag = dvd_neg ? -dividend : dividend;
   assign dsr_mag = dsr_neg ? -divisor : divisor;

   assign shifted = {prem_q[M-1:0], quo_q[N-1]};
   assign ge      = shifted >= {1'b0, dsr_q};
   assign diff    = shifted - {1'b0, dsr_q};

   // The stored partial remainder is always below the divisor, so its top bit stays zero.
   assign unused_prem_msb = prem_q[M];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         prem_q    <= '0;
         quo_q     <= '0;
         dsr_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         tag_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         tag_out   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  tag_q    <= tag_in;
                  q_neg_q  <= dvd_neg ^ dsr_neg;
                  r_neg_q  <= dvd_neg;
                  quo_q    <= dvd_mag;
                  dsr_q    <= dsr_mag;
                  in_ready <= 1'b0;
                  if (divisor == '0) begin
                     quotient  <= '1;
                     remainder <= dividend[M-1:0];
                     div_zero  <= 1'b1;
                     tag_out   <= tag_in;
                     state_q   <= StDone;
                  end else begin
                     cnt_q   <= CW'(N - 1);
                     prem_q  <= '0;
                     state_q <= StCalc;
                  end
               end
            end
            StCalc: begin
               prem_q <= ge ? diff : shifted;
               quo_q  <= {quo_q[N-2:0], ge};
               cnt_q  <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               quotient  <= q_neg_q ? -quo_q : quo_q;
               remainder <= r_neg_q ? -prem_q[M-1:0] : prem_q[M-1:0];
               div_zero  <= 1'b0;
               tag_out   <= tag_q;
               out_valid <= 1'b1;
               state_q   <= StDone;
            end
            StDone: begin
               // The divide-by-zero path enters here with out_valid still low for one cycle.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_iter.sv
// Scoreboard bench for divider_iter: directed corner cases plus randomized requests checked
// against an integer-arithmetic reference model.
module tb_divider_iter;

   localparam int unsigned N  = 16;
   localparam int unsigned M  = 8;
   localparam int unsigned TW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          signed_op = 1'b0;
   logic [N-1:0]  dividend = '0;
   logic [M-1:0]  divisor = '0;
   logic [TW-1:0] tag_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [N-1:0]  quotient;
   logic [M-1:0]  remainder;
   logic          div_zero;
   logic [TW-1:0] tag_out;

   divider_iter #(.N(N), .M(M), .TW(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .signed_op (signed_op),
      .dividend  (dividend),
      .divisor   (divisor),
      .tag_in    (tag_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .tag_out   (tag_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]  q;
      logic [M-1:0]  r;
      logic          dz;
      logic [TW-1:0] tag;
      int            acc;
      int            lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   ready_mode = 0;
   int   stall_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input bit s, input logic [N-1:0] a, input logic [M-1:0] b,
                                  input logic [TW-1:0] t);
      exp_t   e;
      longint sa, sbv, q, r;
      e.tag = t;
      e.acc = 0;
      if (b == '0) begin
         e.q   = '1;
         e.r   = a[M-1:0];
         e.dz  = 1'b1;
         e.lat = 1;
      end else begin
         if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
         end else begin
            sa  = longint'(a);
            sbv = longint'(b);
         end
         q     = sa / sbv;
         r     = sa % sbv;
         e.q   = q[N-1:0];
         e.r   = r[M-1:0];
         e.dz  = 1'b0;
         e.lat = N + 1;
      end
      return e;
   endfunction

   // out_ready: 0 = always ready, 1 = random, 2 = stall 5 cycles after out_valid rises
   always @(posedge clk) begin
      #1;
      if (ready_mode == 0) begin
         out_ready = 1'b1;
      end else if (ready_mode == 1) begin
         out_ready = 1'($urandom_range(0, 1));
      end else begin
         if (out_valid) stall_cnt++;
         else stall_cnt = 0;
         out_ready = (stall_cnt > 5);
      end
   end

   task automatic issue(input bit s, input logic [N-1:0] a, input logic [M-1:0] b,
                        input logic [TW-1:0] t);
      int   w = 0;
      exp_t e;
      @(negedge clk);
      in_valid  = 1'b1;
      signed_op = s;
      dividend  = a;
      divisor   = b;
      tag_in    = t;
      while (!in_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk(in_ready === 1'b1, "accept_timeout", longint'(in_ready), 1);
      if (in_ready === 1'b1) begin
         e     = model(s, a, b, t);
         e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      signed_op = 1'($urandom);
      dividend  = N'($urandom);
      divisor   = M'($urandom);
      tag_in    = TW'($urandom);
   endtask

   logic          pv = 1'b0;
   logic          pr = 1'b0;
   logic [N-1:0]  pq;
   logic [M-1:0]  prm;
   logic          pdz;
   logic [TW-1:0] ptag;
   exp_t          got;

   always @(negedge clk) begin
      if (rst) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr) begin
            chk(out_valid === 1'b1, "hold_valid", longint'(out_valid), 1);
            chk(quotient === pq, "hold_quotient", longint'(quotient), longint'(pq));
            chk(remainder === prm && div_zero === pdz && tag_out === ptag, "hold_rem_dz_tag",
                longint'({remainder, div_zero, tag_out}), longint'({prm, pdz, ptag}));
            chk(in_ready === 1'b0, "hold_in_ready", longint'(in_ready), 0);
         end
         if (pv && pr) begin
            chk(out_valid === 1'b0, "release_valid", longint'(out_valid), 0);
            chk(in_ready === 1'b1, "release_in_ready", longint'(in_ready), 1);
         end
         if (out_valid === 1'b1 && !pv) begin
            if (sb.size() == 0) chk(1'b0, "unexpected_output", longint'(out_valid), 0);
            else chk(cyc - sb[0].acc == sb[0].lat, "latency", cyc - sb[0].acc, sb[0].lat);
         end
         if (out_valid === 1'b1 && out_ready && sb.size() != 0) begin
            got = sb.pop_front();
            chk(quotient === got.q, "quotient", longint'(quotient), longint'(got.q));
            chk(remainder === got.r, "remainder", longint'(remainder), longint'(got.r));
            chk(div_zero === got.dz, "div_zero", longint'(div_zero), longint'(got.dz));
            chk(tag_out === got.tag, "tag_out", longint'(tag_out), longint'(got.tag));
         end
         pv   = (out_valid === 1'b1);
         pr   = out_ready;
         pq   = quotient;
         prm  = remainder;
         pdz  = div_zero;
         ptag = tag_out;
      end
   end

   task automatic check_reset_outputs(input string tagname);
      chk(in_ready === 1'b1, {tagname, "_in_ready"}, longint'(in_ready), 1);
      chk(out_valid === 1'b0, {tagname, "_out_valid"}, longint'(out_valid), 0);
      chk(quotient === '0 && remainder === '0, {tagname, "_q_r"},
          longint'({quotient, remainder}), 0);
      chk(div_zero === 1'b0 && tag_out === '0, {tagname, "_dz_tag"},
          longint'({div_zero, tag_out}), 0);
   endtask

   initial begin
      logic          s;
      logic [N-1:0]  a;
      logic [M-1:0]  b;
      int            w;

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      issue(1'b0, 16'd1000, 8'd7, 4'd3);
      issue(1'b1, 16'hFC18, 8'h07, 4'd4);
      issue(1'b1, 16'd1000, 8'hF9, 4'd5);
      issue(1'b0, 16'h04D2, 8'h00, 4'd6);
      issue(1'b1, 16'h04D2, 8'h00, 4'd7);
      issue(1'b1, 16'h8000, 8'hFF, 4'd8);
      issue(1'b1, 16'h8000, 8'h80, 4'd9);
      issue(1'b0, 16'hFFFF, 8'h80, 4'd10);

      // Backpressure: second request is held on the input until the first result drains.
      ready_mode = 2;
      issue(1'b0, 16'd1234, 8'd10, 4'd11);
      issue(1'b1, 16'hFED4, 8'd9, 4'd12);
      w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      ready_mode = 0;

      // Reset five cycles into the calculation discards the operation.
      issue(1'b0, 16'd50000, 8'd3, 4'd13);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      sb.delete();
      @(negedge clk);
      #1;
      rst = 1'b0;
      issue(1'b0, 16'd255, 8'd15, 4'd14);

      ready_mode = 1;
      for (int i = 0; i < 150; i++) begin
         s = 1'($urandom_range(0, 1));
         a = N'($urandom);
         b = M'($urandom);
         case ($urandom_range(0, 9))
            0: b = '0;
            1: begin
               a = {1'b1, {(N-1){1'b0}}};
               b = '1;
            end
            2: b = {1'b1, {(M-1){1'b0}}};
            3: b = M'(1);
            default: ;
         endcase
         issue(s, a, b, TW'($urandom));
      end

      ready_mode = 0;
      w = 0;
      while (sb.size() != 0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk(sb.size() == 0, "drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
